// File: rtl/alu_pkg.sv
// Shared definitions for the ALU / iterative multiply-divide unit:
// operation codes and the iterative-unit state encoding.
package alu_pkg;

  // Combinational operations (ALUop[3] = 0)
  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_LUI   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;

  // Iterative operations (ALUop[3] = 1); bit 1 selects divide, bit 0 signed
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_MULT  = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_DIV   = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/alu_muldiv_if.sv
// Bus bundle between the ALU/mul-div unit and its user.
//
// Handshake: start is a request that is only honoured when busy=0 and
// ALUop[3]=1; A, B and ALUop are captured on that edge. There is no
// backpressure: done is a single-cycle pulse after which Hi/Lo hold the
// result until the next operation completes. Result and the flags are
// purely combinational from A, B, shamt and ALUop.
interface alu_muldiv_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  import alu_pkg::*;

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [SHW-1:0]   shamt;
  logic [3:0]       ALUop;
  logic             start;
  logic [WIDTH-1:0] Result;
  logic             Overflow;
  logic             CarryOut;
  logic             Zero;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  state_t           dbg_state;

  modport master (
    output A, B, shamt, ALUop, start,
    input  Result, Overflow, CarryOut, Zero, busy, done, Hi, Lo, dbg_state
  );

  modport slave (
    input  A, B, shamt, ALUop, start,
    output Result, Overflow, CarryOut, Zero, busy, done, Hi, Lo, dbg_state
  );

endinterface

// File: rtl/alu_comb.sv
// Zero-latency ALU: logic ops, LUI, shift, and the shared add/sub path
// that also produces SLT/SLTU and the Overflow/CarryOut/Zero flags.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             carry_out,
  output logic             zero
);

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] sum;
  logic             carry;

  // Add/sub path: subtraction is A + ~B + 1 so a single adder serves all
  always_comb begin
    is_sub    = (alu_op == OP_SUB) || (alu_op == OP_SLT) || (alu_op == OP_SLTU);
    b_eff     = is_sub ? ~b : b;
    sum_ext   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    sum       = sum_ext[WIDTH-1:0];
    carry     = sum_ext[WIDTH];
    overflow  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    // For subtraction the flag reports a borrow, i.e. the inverted carry
    carry_out = is_sub ? ~carry : carry;
    zero      = (sum == '0);
  end

  // Result mux; iterative opcodes yield zero here
  always_comb begin
    result = '0;
    case (alu_op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = sum;
      OP_LUI:  result = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLL:  result = b << shamt;
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, ~carry};
      OP_SUB:  result = sum;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ overflow};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_muldiv.sv
// ALU with an iterative multiply/divide unit. Multiply is shift-add and
// divide is restoring shift-subtract, both on operand magnitudes over a
// shared 2*WIDTH accumulator; signs are applied in a final FIX cycle.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic         clk,
  input  logic         rst,
  alu_muldiv_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t             state, next_state;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_q;     // {divide, signed}
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               accept;
  logic [WIDTH-1:0]   init_lo, a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
  logic               sgn_diff;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
  endfunction

  alu_comb #(.WIDTH(WIDTH), .SHW(SHW)) u_comb (
    .a         (bus.A),
    .b         (bus.B),
    .shamt     (bus.shamt),
    .alu_op    (bus.ALUop),
    .result    (bus.Result),
    .overflow  (bus.Overflow),
    .carry_out (bus.CarryOut),
    .zero      (bus.Zero)
  );

  // One iteration step of each algorithm and the sign fix-up
  always_comb begin
    accept   = bus.start && bus.ALUop[3];
    // Multiply seeds the low half with the multiplier, divide with the dividend
    init_lo  = bus.ALUop[1] ? mag(bus.A, bus.ALUop[0]) : mag(bus.B, bus.ALUop[0]);
    a_mag    = mag(a_q, op_q[0]);
    b_mag    = mag(b_q, op_q[0]);

    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Remainder can briefly need WIDTH+1 bits after the left shift
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_mag};
    div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

    sgn_diff = op_q[0] && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
    prod     = sgn_diff ? (~acc + 1'b1) : acc;
    fix_hi   = prod[2*WIDTH-1:WIDTH];
    fix_lo   = prod[WIDTH-1:0];
    if (op_q[1]) begin
      fix_lo = sgn_diff ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
      fix_hi = (op_q[0] && a_q[WIDTH-1]) ? (~acc[2*WIDTH-1:WIDTH] + 1'b1)
                                         : acc[2*WIDTH-1:WIDTH];
      if (b_q == '0) begin
        fix_lo = '1;
        fix_hi = a_q;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (accept) next_state = ST_RUN;
      ST_RUN:  if (cnt == LAST) next_state = ST_FIX;
      ST_FIX:  next_state = ST_DONE;
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Operand capture, iteration and result write
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
      acc  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          cnt  <= '0;
          op_q <= bus.ALUop[1:0];
          a_q  <= bus.A;
          b_q  <= bus.B;
          acc  <= {{WIDTH{1'b0}}, init_lo};
        end
        ST_RUN: begin
          acc <= op_q[1] ? div_next : mul_next;
          cnt <= cnt + 1'b1;
        end
        ST_FIX: begin
          hi_q <= fix_hi;
          lo_q <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_DONE);
  assign bus.Hi        = hi_q;
  assign bus.Lo        = lo_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv (WIDTH=32): directed combinational vectors checked
// inline, iterative results checked by a done-triggered scoreboard monitor.
module tb_alu_muldiv;
  import alu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;

  int tests = 0;
  int fails = 0;
  logic [2*W-1:0] exp_q[$];

  alu_muldiv_if #(.WIDTH(W)) bus ();

  alu_muldiv #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no done");
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        check("hi_lo", {bus.Hi, bus.Lo}, e);
      end
    end
  end

  // Driver: combinational op, checks Result and (optionally) flags
  task automatic comb_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [4:0] sh, input logic [W-1:0] exp_res,
                         input logic chk_flags, input logic [2:0] exp_flags);
    @(negedge clk);
    bus.ALUop = op;
    bus.A     = a;
    bus.B     = b;
    bus.shamt = sh;
    #1;
    check({name, "_result"}, bus.Result, exp_res);
    if (chk_flags)
      check({name, "_flags_ovf_cout_zero"}, {bus.Overflow, bus.CarryOut, bus.Zero}, exp_flags);
  endtask

  // Driver: iterative op; queues the expected result and checks latency.
  // inject re-pulses start with other operands around edge 10.
  task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input logic inject);
    int n;
    logic got;
    @(negedge clk);
    bus.ALUop = op;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    exp_q.push_back({ehi, elo});
    @(posedge clk);
    n = 1;
    #1;
    bus.start = 1'b0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (inject && n == 9) begin
        bus.start = 1'b1;
        bus.ALUop = OP_MULTU;
        bus.A     = 32'h0000_0007;
        bus.B     = 32'h0000_0009;
      end
      if (inject && n == 10) bus.start = 1'b0;
      if (bus.done === 1'b1) got = 1'b1;
    end
    check({name, "_latency"}, n, W + 2);
    @(posedge clk);
    #1;
    check({name, "_idle_after_done"}, {bus.busy, bus.done}, 2'b00);
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.shamt = '0;
    bus.ALUop = OP_AND;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy_done", {bus.busy, bus.done}, 2'b00);
    check("reset_hi_lo", {bus.Hi, bus.Lo}, 64'h0);
    check("reset_state", bus.dbg_state, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;

    // Combinational vectors: {Overflow, CarryOut, Zero}
    comb_op("add_ovf",   OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b1, 3'b100);
    comb_op("sub_zero",  OP_SUB,  32'd5,         32'd5,         5'd0,  32'h0000_0000, 1'b1, 3'b001);
    comb_op("add_carry", OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b1, 3'b011);
    comb_op("sub_borrow",OP_SUB,  32'd3,         32'd5,         5'd0,  32'hFFFF_FFFE, 1'b1, 3'b010);
    comb_op("and",       OP_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0,  32'h00F0_00F0, 1'b0, 3'b000);
    comb_op("or",        OP_OR,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0,  32'hFFF0_FFF0, 1'b0, 3'b000);
    comb_op("lui",       OP_LUI,  32'h0,         32'h1234_ABCD, 5'd0,  32'hABCD_0000, 1'b0, 3'b000);
    comb_op("sll31",     OP_SLL,  32'h0,         32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 3'b000);
    comb_op("sll4",      OP_SLL,  32'h0,         32'h0000_0003, 5'd4,  32'h0000_0030, 1'b0, 3'b000);
    comb_op("sltu",      OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  32'h0000_0001, 1'b0, 3'b000);
    comb_op("slt_neg1",  OP_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000, 1'b0, 3'b000);
    comb_op("slt_ovf",   OP_SLT,  32'h8000_0000, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b1, 3'b100);
    comb_op("iter_zero", OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0,  32'h0000_0000, 1'b0, 3'b000);

    // start with a combinational opcode must not launch anything
    @(negedge clk);
    bus.ALUop = OP_ADD;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("start_comb_ignored", bus.busy, 1'b0);

    // MULT with a spurious start mid-run, then an immediate back-to-back MULTU
    run_op("mult_neg2x3", OP_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1);
    run_op("multu_max",   OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

    // Hi/Lo hold across unrelated combinational activity
    comb_op("hold_add", OP_ADD, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, 3'b000);
    repeat (4) @(posedge clk);
    #1;
    check("hold_hi_lo", {bus.Hi, bus.Lo}, 64'hFFFF_FFFE_0000_0001);

    run_op("div_m7_2",     OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_by0",     OP_DIVU, 32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b0);
    run_op("div_min_m1",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("divu_100_7",   OP_DIVU, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
    run_op("div_m5_by0",   OP_DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
    run_op("mult_7_m3",    OP_MULT, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

    // Reset at edge 20 of a DIV aborts it with no done pulse
    @(negedge clk);
    bus.ALUop = OP_DIV;
    bus.A     = 32'd1000;
    bus.B     = 32'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (18) @(posedge clk);
    #1;
    rst       = 1'b1;
    bus.ALUop = OP_ADD;
    bus.A     = 32'd2;
    bus.B     = 32'd3;
    @(posedge clk);
    #1;
    check("abort_busy_done", {bus.busy, bus.done}, 2'b00);
    check("abort_hi_lo", {bus.Hi, bus.Lo}, 64'h0);
    check("abort_comb_in_rst", bus.Result, 32'd5);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("abort_hi_lo_later", {bus.Hi, bus.Lo}, 64'h0);

    run_op("divu_after_rst", OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning datapath width in bits (even, >= 8).
REQ-002 The block SHALL have parameter SHW, default $clog2(WIDTH), meaning shift-amount width.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: the reset, synchronous and active-high.
REQ-005 Port A and B, input, WIDTH each: operands.
REQ-006 Port shamt, input, SHW: shift amount.
REQ-007 Port ALUop, input, 4: operation code; 0xxx combinational, 10xx iterative.
REQ-008 Port Result, output, WIDTH: combinational result for ALUop[3]=0, else 0.
REQ-009 Ports Overflow, CarryOut and Zero, output, 1 each: flags of the add/sub path.
REQ-010 Port start, input, 1: launch an iterative op; sampled only in IDLE.
REQ-011 Port busy, output, 1: iterative unit not in IDLE.
REQ-012 Port done, output, 1: one-cycle pulse; Hi/Lo hold a new result.
REQ-013 Ports Hi and Lo, output, WIDTH each: registered iterative result.

Function
REQ-014 Combinational ops SHALL be 0000 AND, 0001 OR, 0010 ADD, 0011 LUI (B[WIDTH/2-1:0] followed by WIDTH/2 zeros), 0100 SLL (B<<shamt), 0101 SLTU, 0110 SUB, 0111 SLT, all zero-latency and independent of busy.
REQ-015 SUB, SLT and SLTU SHALL compute A+~B+1; SLT is signed less-than including overflow; SLTU is the inverted carry.
REQ-016 Overflow SHALL be the signed overflow of the add/sub path, CarryOut the unsigned carry (ADD) or borrow (SUB), and Zero=1 iff the add/sub sum is 0.
REQ-017 Iterative ops SHALL be 1000 MULTU, 1001 MULT, 1010 DIVU, 1011 DIV.
REQ-018 The FSM SHALL have states IDLE, RUN, FIX and DONE.
REQ-019 IDLE->RUN SHALL occur on an edge with start=1 and ALUop[3]=1; A, B and ALUop are latched on that edge, and the RUN counter is cleared.
REQ-020 start with ALUop[3]=0 SHALL be ignored; start outside IDLE SHALL be ignored, with latched operands unchanged.
REQ-021 RUN SHALL perform one shift-add (multiply) or restoring shift-subtract (divide) step per edge on operand magnitudes, for exactly WIDTH edges, then move to FIX.
REQ-022 FIX SHALL apply signs for signed ops (product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign), write Hi/Lo, and move to DONE.
REQ-023 DONE SHALL assert done for one cycle, then return to IDLE; busy=1 in RUN, FIX and DONE.
REQ-024 Latency: counting the start-sampling edge as edge 1, done SHALL be high after edge WIDTH+2 and Hi/Lo valid from then on.
REQ-025 MULT/MULTU results SHALL be Hi:Lo = full 2*WIDTH-bit product; DIV/DIVU results SHALL be Lo=quotient, Hi=remainder.
REQ-026 Division by zero SHALL give Lo=all ones, Hi=dividend (as given), with the same latency.
REQ-027 Signed DIV of most-negative by -1 SHALL give Lo=most-negative, Hi=0.
REQ-028 Hi and Lo SHALL hold their values until the next FIX write.
REQ-029 A back-to-back start SHALL be accepted in the IDLE cycle following DONE.

Reset
REQ-030 While rst=1 at an edge, the FSM SHALL go to IDLE with Hi=0, Lo=0, done=0, busy=0, and counter and latched operands cleared.
REQ-031 rst during RUN or FIX SHALL abort the operation; no done pulse and no Hi/Lo update.
REQ-032 Combinational outputs (Result, flags) SHALL be unaffected by rst.

Structure
REQ-033 Package alu_pkg SHALL hold the ALUop code constants and the FSM state enum.
REQ-034 The combinational ops and flags SHALL live in one sub-module, alu_comb.
REQ-035 The iterative FSM, counter and shared 2*WIDTH accumulator SHALL live in alu_muldiv.

Verification (WIDTH=32)
REQ-036 ADD 0x7FFFFFFF+1 -> Result 0x80000000, Overflow=1, CarryOut=0, Zero=0; SUB 5-5 -> Zero=1, CarryOut=0.
REQ-037 MULT A=0xFFFFFFFE (-2), B=3 -> done after edge 34, Hi=0xFFFFFFFF, Lo=0xFFFFFFFA; MULTU 0xFFFFFFFF*0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
REQ-038 DIV -7/2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIVU 100/0 -> Lo=0xFFFFFFFF, Hi=100.
REQ-039 start pulsed again at edge 10 of a MULT -> ignored; result and latency unchanged; a new start in the IDLE cycle after done -> accepted.
REQ-040 rst asserted at edge 20 of a DIV -> busy=0 next cycle, no done, Hi=Lo=0.
REQ-041 Signed DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
